// File: rtl/voting_session.sv
// Clocked voting session: opens on start, locks one ballot per voter, closes on
// command, all-voted or timeout, tallies voters serially and holds the result.
module voting_session #(
    parameter int N_VOTERS    = 5,
    parameter int THRESHOLD   = N_VOTERS / 2 + 1,
    parameter int TIMEOUT_CYC = 0,
    parameter int CW          = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                close,
    input  logic [N_VOTERS-1:0] vote_en,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic [N_VOTERS-1:0] voted,
    output logic                busy,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt,
    output logic                result,
    output logic                result_valid,
    output logic                timeout
);

    // state  | meaning
    // IDLE   | no session since reset
    // VOTING | ballots being collected
    // COUNT  | serial tally, one voter per cycle
    // RESULT | tallies and pass/fail held until next start
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VOTING = 2'd1;
    localparam logic [1:0] COUNT  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam int IW = $clog2(N_VOTERS);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]          state;
    logic [N_VOTERS-1:0] ballot;
    logic [TW-1:0]       timer;
    logic [IW-1:0]       index;

    logic [N_VOTERS-1:0] new_votes;
    logic [N_VOTERS-1:0] voted_nx;
    logic [N_VOTERS-1:0] ballot_nx;
    logic                all_voted;
    logic                timer_hit;
    logic                vote_exit;
    logic                bit_yes;
    logic                bit_no;
    logic [CW-1:0]       yes_nx;
    logic [CW-1:0]       no_nx;
    logic                last_idx;

    always_comb begin
        new_votes = vote_en & ~voted;
        voted_nx  = voted | new_votes;
        ballot_nx = (ballot & ~new_votes) | (vote_yes & new_votes);
        // Ballots landing on this edge count toward the all-voted close
        all_voted = &voted_nx;
        timer_hit = (TIMEOUT_CYC != 0) && (timer == TW'(TIMEOUT_CYC - 1));
        vote_exit = close | all_voted | timer_hit;
        bit_yes   = voted[index] & ballot[index];
        bit_no    = voted[index] & ~ballot[index];
        yes_nx    = yes_cnt + CW'(bit_yes);
        no_nx     = no_cnt + CW'(bit_no);
        last_idx  = (index == IW'(N_VOTERS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            voted        <= '0;
            ballot       <= '0;
            yes_cnt      <= '0;
            no_cnt       <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            timer        <= '0;
            index        <= '0;
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (start) begin
                        state        <= VOTING;
                        voted        <= '0;
                        ballot       <= '0;
                        yes_cnt      <= '0;
                        no_cnt       <= '0;
                        result       <= 1'b0;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                        timer        <= '0;
                        index        <= '0;
                        busy         <= 1'b1;
                    end
                end
                VOTING: begin
                    voted  <= voted_nx;
                    ballot <= ballot_nx;
                    if (vote_exit) begin
                        state   <= COUNT;
                        index   <= '0;
                        // Timer only reports when nothing else closed the vote
                        timeout <= timer_hit & ~close & ~all_voted;
                    end else if (TIMEOUT_CYC != 0) begin
                        timer <= timer + TW'(1);
                    end
                end
                COUNT: begin
                    yes_cnt <= yes_nx;
                    no_cnt  <= no_nx;
                    index   <= index + IW'(1);
                    if (last_idx) begin
                        state        <= RESULT;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= (yes_nx >= CW'(THRESHOLD));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voting_session.sv
// Randomized bench for voting_session: three configurations run side by side
// against a session-level reference model.
module tb_voting_session;

    localparam int P_IDLE = 0, P_VOTE = 1, P_COUNT = 2, P_RES = 3;
    localparam int NV[3] = '{5, 5, 8};
    localparam int TH[3] = '{3, 3, 5};
    localparam int TO[3] = '{0, 20, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d_start[3];
    logic       d_close[3];
    logic [7:0] d_en[3];
    logic [7:0] d_yes[3];

    logic [4:0] vo0, vo1;
    logic [7:0] vo2;
    logic       bz0, bz1, bz2, rv0, rv1, rv2, rs0, rs1, rs2, tm0, tm1, tm2;
    logic [2:0] yc0, nc0, yc1, nc1;
    logic [3:0] yc2, nc2;

    voting_session #(.N_VOTERS(5), .THRESHOLD(3), .TIMEOUT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(d_start[0]), .close(d_close[0]),
        .vote_en(d_en[0][4:0]), .vote_yes(d_yes[0][4:0]), .voted(vo0), .busy(bz0),
        .yes_cnt(yc0), .no_cnt(nc0), .result(rs0), .result_valid(rv0), .timeout(tm0));

    voting_session #(.N_VOTERS(5), .THRESHOLD(3), .TIMEOUT_CYC(20)) dut1 (
        .clk(clk), .rst(rst), .start(d_start[1]), .close(d_close[1]),
        .vote_en(d_en[1][4:0]), .vote_yes(d_yes[1][4:0]), .voted(vo1), .busy(bz1),
        .yes_cnt(yc1), .no_cnt(nc1), .result(rs1), .result_valid(rv1), .timeout(tm1));

    voting_session #(.N_VOTERS(8), .THRESHOLD(5), .TIMEOUT_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .start(d_start[2]), .close(d_close[2]),
        .vote_en(d_en[2]), .vote_yes(d_yes[2]), .voted(vo2), .busy(bz2),
        .yes_cnt(yc2), .no_cnt(nc2), .result(rs2), .result_valid(rv2), .timeout(tm2));

    // Reference model: session phase, locked ballots and final tallies
    int         m_phase[3];
    logic [7:0] m_voted[3];
    logic [7:0] m_ballot[3];
    int         m_timer[3];
    int         m_left[3];
    int         m_yes[3];
    int         m_no[3];
    logic       m_res[3];
    logic       m_tmo[3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mask_of(input int k);
        return 8'((1 << NV[k]) - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = P_IDLE; m_voted[k] = '0; m_ballot[k] = '0;
            m_timer[k] = 0; m_left[k] = 0; m_yes[k] = 0; m_no[k] = 0;
            m_res[k] = 1'b0; m_tmo[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] fresh;
        logic       all_in, t_hit;
        case (m_phase[k])
            P_IDLE, P_RES: if (d_start[k]) begin
                m_phase[k] = P_VOTE; m_voted[k] = '0; m_ballot[k] = '0;
                m_timer[k] = 0; m_tmo[k] = 1'b0;
                m_yes[k] = 0; m_no[k] = 0; m_res[k] = 1'b0;
            end
            P_VOTE: begin
                fresh = d_en[k] & ~m_voted[k] & mask_of(k);
                m_ballot[k] = (m_ballot[k] & ~fresh) | (d_yes[k] & fresh);
                m_voted[k] = m_voted[k] | fresh;
                all_in = (m_voted[k] == mask_of(k));
                t_hit = (TO[k] != 0) && (m_timer[k] == TO[k] - 1);
                if (d_close[k] || all_in || t_hit) begin
                    m_phase[k] = P_COUNT;
                    m_left[k] = NV[k];
                    m_tmo[k] = t_hit && !d_close[k] && !all_in;
                end else begin
                    m_timer[k]++;
                end
            end
            default: begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_phase[k] = P_RES;
                    m_yes[k] = $countones(m_voted[k] & m_ballot[k]);
                    m_no[k] = $countones(m_voted[k] & ~m_ballot[k]);
                    m_res[k] = (m_yes[k] >= TH[k]);
                end
            end
        endcase
    endtask

    task automatic check_all();
        logic [7:0] vo;
        logic [3:0] yc, nc;
        logic       bz, rv, rs, tm;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin vo = {3'b0, vo0}; yc = {1'b0, yc0}; nc = {1'b0, nc0}; bz = bz0; rv = rv0; rs = rs0; tm = tm0; end
                1: begin vo = {3'b0, vo1}; yc = {1'b0, yc1}; nc = {1'b0, nc1}; bz = bz1; rv = rv1; rs = rs1; tm = tm1; end
                default: begin vo = vo2; yc = yc2; nc = nc2; bz = bz2; rv = rv2; rs = rs2; tm = tm2; end
            endcase
            chk($sformatf("busy%0d", k), 32'(bz), 32'(m_phase[k] == P_VOTE || m_phase[k] == P_COUNT));
            chk($sformatf("result_valid%0d", k), 32'(rv), 32'(m_phase[k] == P_RES));
            chk($sformatf("voted%0d", k), 32'(vo), 32'(m_voted[k]));
            chk($sformatf("timeout%0d", k), 32'(tm), 32'(m_tmo[k]));
            if (m_phase[k] == P_RES || m_phase[k] == P_IDLE) begin
                chk($sformatf("yes_cnt%0d", k), 32'(yc), 32'(m_yes[k]));
                chk($sformatf("no_cnt%0d", k), 32'(nc), 32'(m_no[k]));
                chk($sformatf("result%0d", k), 32'(rs), 32'(m_res[k]));
            end
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            d_start[k] = 1'b0; d_close[k] = 1'b0; d_en[k] = '0; d_yes[k] = '0;
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_inputs(input int k);
        d_yes[k] = 8'($urandom);
        case (m_phase[k])
            P_VOTE: begin
                d_start[k] = ($urandom_range(0, 7) == 0);
                if (k == 1) begin
                    d_close[k] = (m_timer[k] == TO[k] - 1) ? 1'($urandom_range(0, 1))
                                                           : ($urandom_range(0, 59) == 0);
                    d_en[k] = 8'($urandom & $urandom & $urandom & $urandom & $urandom);
                end else begin
                    d_close[k] = ($urandom_range(0, 24) == 0);
                    d_en[k] = 8'($urandom & $urandom & $urandom);
                end
            end
            P_COUNT: begin
                d_start[k] = 1'($urandom); d_close[k] = 1'($urandom); d_en[k] = 8'($urandom);
            end
            default: begin
                d_start[k] = ($urandom_range(0, 3) == 0);
                d_close[k] = 1'($urandom); d_en[k] = 8'($urandom);
            end
        endcase
    endtask

    initial begin
        int n_rst = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Directed sessions run in parallel on all three instances
        d_start[0] = 1'b1; d_start[1] = 1'b1; d_start[2] = 1'b1;
        tick();
        for (int t = 0; t < 8; t++) begin
            clear_inputs();
            if (t < 5) begin d_en[0] = 8'(1 << t); d_yes[0] = (t < 3) ? 8'hff : 8'h00; end
            if (t < 2) begin d_en[1] = 8'(1 << t); d_yes[1] = 8'hff; end
            d_en[2] = 8'(1 << t); d_yes[2] = (t < 4) ? 8'hff : 8'h00;
            tick();
        end
        clear_inputs();
        for (int t = 0; t < 20; t++) tick();
        chk("dir_n5_yes", 32'(yc0), 3);
        chk("dir_n5_no", 32'(nc0), 2);
        chk("dir_n5_result", 32'(rs0), 1);
        chk("dir_n5_timeout", 32'(tm0), 0);
        chk("dir_to_timeout", 32'(tm1), 1);
        chk("dir_to_yes", 32'(yc1), 2);
        chk("dir_to_result", 32'(rs1), 0);
        chk("dir_n8_yes", 32'(yc2), 4);
        chk("dir_n8_no", 32'(nc2), 4);
        chk("dir_n8_result", 32'(rs2), 0);

        for (int it = 0; it < 4000; it++) begin
            if (m_phase[0] == P_COUNT && m_left[0] == NV[0] - 2 && n_rst < 4 &&
                $urandom_range(0, 1) == 1) begin
                n_rst++;
                clear_inputs();
                #1 rst = 1'b1;
                #1 model_reset();
                check_all();
                chk("rst_yes0", 32'(yc0), 0);
                chk("rst_busy0", 32'(bz0), 0);
                #1 rst = 1'b0;
                tick();
            end else begin
                for (int k = 0; k < 3; k++) rand_inputs(k);
                tick();
            end
        end
        chk("rst_mid_count_seen", 32'(n_rst > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
